// File: rtl/rect_object.sv
// rect_object: frame-ticked rectangle sprite (paddle or bouncing ball) drawn through a req/grant pixel port; RECT_OBJECT_HIT_EN builds hit_left/hit_right
module rect_object #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int XDIM = 2,
  parameter int YDIM = 50,
  parameter int X0 = 2,
  parameter int Y0 = 59,
  parameter int STEP = 1,
  parameter int MODE = 0,
  parameter int W = 20,
  parameter logic [2:0] CLR = 3'b111,
  parameter logic [2:0] ALT = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       enable,
  input  logic       go,
  input  logic       draw,
  input  logic [1:0] Dir,
  input  logic       Xcol,
  input  logic       Ycol,
  input  logic       grant,
  output logic       req,
  output logic       plot,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic       frame_done,
  output logic       hit_left,
  output logic       hit_right
);
  localparam logic [8:0] XMAX = 9'(XSCREEN - XDIM);
  localparam logic [7:0] YMAX = 8'(YSCREEN - YDIM);
  localparam logic [8:0] XSTEP = 9'(STEP);
  localparam logic [7:0] YSTEP = 8'(STEP);
  typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, UPDATE, MOVE} state_t;
  state_t state, state_n;
  logic [W-1:0] div;
  logic [7:0] xc, nx, x_inc, x_dec, nx_c;
  logic [6:0] yc, ny, y_inc, y_dec, ny_c;
  logic [8:0] xs;
  logic [7:0] ys;
  logic xdir, ydir, ndx, ndy, ndx_c, ndy_c;
  logic x_hi, x_lo, y_hi, y_lo;
  logic tick, last_x, last;
  assign tick = div == '0;
  assign req = enable && (state == DRAW || state == ERASE);
  assign plot = req && grant;
  assign last_x = xc == 8'(XDIM - 1);
  assign last = last_x && yc == 7'(YDIM - 1);
  assign frame_done = plot && state == DRAW && last;
  assign VGA_X = X + xc;
  assign VGA_Y = Y + yc;
  assign VGA_COLOR = state == ERASE ? ALT : CLR;
  always_comb begin
    xs = {1'b0, X} + XSTEP;
    ys = {1'b0, Y} + YSTEP;
    x_hi = xs >= XMAX;
    x_lo = {1'b0, X} <= XSTEP;
    y_hi = ys >= YMAX;
    y_lo = {1'b0, Y} <= YSTEP;
    x_inc = x_hi ? XMAX[7:0] : xs[7:0];
    x_dec = x_lo ? '0 : X - XSTEP[7:0];
    y_inc = y_hi ? YMAX[6:0] : ys[6:0];
    y_dec = y_lo ? '0 : Y - YSTEP[6:0];
    nx_c = MODE == 1 ? (xdir ? x_inc : x_dec) : X;
    ny_c = MODE == 1 ? (ydir ? y_inc : y_dec) : Dir == 2'b01 ? y_dec : Dir == 2'b10 ? y_inc : Y;
    ndx_c = MODE == 1 ? xdir ^ ((xdir ? x_hi : x_lo) | Xcol) : xdir;
    ndy_c = MODE == 1 ? ydir ^ ((ydir ? y_hi : y_lo) | Ycol) : ydir;
  end
  always_comb begin
    state_n = state;
    if (draw)
      state_n = IDLE;
    else if (enable)
      case (state)
        IDLE:    if (go && tick) state_n = DRAW;
        DRAW:    if (plot && last) state_n = WAIT;
        WAIT:    if (tick) state_n = ERASE;
        ERASE:   if (plot && last) state_n = UPDATE;
        UPDATE:  state_n = MOVE;
        MOVE:    state_n = DRAW;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLOCK_50)
    state <= Reset ? IDLE : state_n;
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      div <= '0;
      X <= 8'(X0);
      Y <= 7'(Y0);
      xdir <= 1'b1;
      ydir <= 1'b0;
      xc <= '0;
      yc <= '0;
      nx <= 8'(X0);
      ny <= 7'(Y0);
      ndx <= 1'b1;
      ndy <= 1'b0;
    end else begin
      div <= div + W'(1);
      if (draw) begin
        X <= 8'(X0);
        Y <= 7'(Y0);
        xdir <= 1'b1;
        ydir <= 1'b0;
        xc <= '0;
        yc <= '0;
      end else if (enable) begin
        if (plot) begin
          xc <= last_x ? '0 : xc + 8'd1;
          if (last_x) yc <= last ? '0 : yc + 7'd1;
        end
        if (state == UPDATE) begin
          nx <= nx_c;
          ny <= ny_c;
          ndx <= ndx_c;
          ndy <= ndy_c;
        end
        if (state == MOVE) begin
          X <= nx;
          Y <= ny;
          xdir <= ndx;
          ydir <= ndy;
        end
      end
    end
  end
`ifdef RECT_OBJECT_HIT_EN
  assign hit_left = MODE == 1 && enable && state == MOVE && nx == '0;
  assign hit_right = MODE == 1 && enable && state == MOVE && {1'b0, nx} == XMAX;
`else
  assign hit_left = 1'b0;
  assign hit_right = 1'b0;
`endif
endmodule

// File: tb/tb_rect_object.sv
// tb_rect_object: paddle and ball instances checked frame by frame against an arithmetic position model
module tb_rect_object;
  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;
  logic Reset, en_p, en_b, go, draw, grant, Xcol, Ycol, sel;
  logic [1:0] Dir;
  logic p_req, p_plot, p_fd, p_hl, p_hr, b_req, b_plot, b_fd, b_hl, b_hr;
  logic [7:0] p_vx, p_x, b_vx, b_x;
  logic [6:0] p_vy, p_y, b_vy, b_y;
  logic [2:0] p_col, b_col;
  logic req_m, plot_m, fd_m, hl_m, hr_m;
  logic [7:0] vx_m, x_m;
  logic [6:0] vy_m, y_m;
  logic [2:0] col_m;
  int n_chk = 0, n_pass = 0;
  int mx, my, mdx, mdy;

  rect_object #(.XDIM(2), .YDIM(50), .X0(2), .Y0(2), .STEP(4), .MODE(0), .W(3)) u_pad (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .enable(en_p), .go(go), .draw(draw), .Dir(Dir),
    .Xcol(Xcol), .Ycol(Ycol), .grant(grant), .req(p_req), .plot(p_plot), .VGA_X(p_vx),
    .VGA_Y(p_vy), .VGA_COLOR(p_col), .X(p_x), .Y(p_y), .frame_done(p_fd),
    .hit_left(p_hl), .hit_right(p_hr));

  rect_object #(.XDIM(2), .YDIM(2), .X0(156), .Y0(1), .STEP(2), .MODE(1), .W(3)) u_ball (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .enable(en_b), .go(go), .draw(draw), .Dir(Dir),
    .Xcol(Xcol), .Ycol(Ycol), .grant(grant), .req(b_req), .plot(b_plot), .VGA_X(b_vx),
    .VGA_Y(b_vy), .VGA_COLOR(b_col), .X(b_x), .Y(b_y), .frame_done(b_fd),
    .hit_left(b_hl), .hit_right(b_hr));

  assign req_m = sel ? b_req : p_req;
  assign plot_m = sel ? b_plot : p_plot;
  assign fd_m = sel ? b_fd : p_fd;
  assign hl_m = sel ? b_hl : p_hl;
  assign hr_m = sel ? b_hr : p_hr;
  assign vx_m = sel ? b_vx : p_vx;
  assign vy_m = sel ? b_vy : p_vy;
  assign x_m = sel ? b_x : p_x;
  assign y_m = sel ? b_y : p_y;
  assign col_m = sel ? b_col : p_col;

  function automatic int yd();
    return sel ? 2 : 50;
  endfunction
  function automatic int x0f();
    return sel ? 156 : 2;
  endfunction
  function automatic int y0f();
    return sel ? 1 : 2;
  endfunction
  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1 grant = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!req_m && k < 40) begin
      step();
      k++;
    end
    chk(tag, req_m, 1);
  endtask

  task automatic reset_model();
    mx = x0f();
    my = y0f();
    mdx = 1;
    mdy = -1;
  endtask

  task automatic scan(input logic [2:0] col, input int n, input bit stall);
    int cnt = 0, cyc = 0, vx, vy, key;
    bit seen[int];
    while (cnt < n && cyc < 2000) begin
      @(posedge CLOCK_50);
      #1 grant = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLOCK_50);
      cyc++;
      chk("scan_pos_x", x_m, mx);
      chk("scan_pos_y", y_m, my);
      chk("scan_hits", {hl_m, hr_m}, 0);
      if (plot_m) begin
        cnt++;
        vx = int'(vx_m);
        vy = int'(vy_m);
        key = vx * 256 + vy;
        chk("pix_color", col_m, col);
        chk("pix_in_rect_once", vx >= mx && vx < mx + 2 && vy >= my && vy < my + yd() && !seen.exists(key), 1);
        seen[key] = 1'b1;
        chk("frame_done", fd_m, col == 3'b111 && cnt == 2 * yd());
      end else
        chk("stall_req_grant", {req_m, grant}, 2'b10);
    end
    chk("scan_count", cnt, n);
  endtask

  task automatic axis(input int p, input int d, input int lim, input logic c, output int np, output int nd);
    int t;
    t = p + d * 2;
    np = clamp(t, 0, lim);
    nd = (t <= 0 || t >= lim || c) ? -d : d;
  endtask

  task automatic frame(input bit stall, input logic [1:0] dv, input logic xcv, input logic ycv);
    int nx, ny, ndx, ndy, d;
    logic hl_e, hr_e;
    scan(3'b111, 2 * yd(), stall);
    step();
    chk("wait_req_low", req_m, 0);
    Dir = dv;
    Xcol = xcv;
    Ycol = ycv;
    wait_req("erase_start");
    scan(3'b000, 2 * yd(), stall);
    if (!sel) begin
      d = dv == 2'b01 ? -1 : dv == 2'b10 ? 1 : 0;
      nx = mx;
      ny = clamp(my + d * 4, 0, 70);
      ndx = mdx;
      ndy = mdy;
    end else begin
      axis(mx, mdx, 158, xcv, nx, ndx);
      axis(my, mdy, 118, ycv, ny, ndy);
    end
    step();
    chk("update_req", req_m, 0);
    chk("update_x_hold", x_m, mx);
    chk("update_hits", {hl_m, hr_m}, 0);
    step();
    chk("move_x_hold", x_m, mx);
    chk("move_y_hold", y_m, my);
    hl_e = 1'b0;
    hr_e = 1'b0;
`ifdef RECT_OBJECT_HIT_EN
    if (sel) begin
      hl_e = nx == 0;
      hr_e = nx == 158;
    end
`endif
    chk("hit_left", hl_m, hl_e);
    chk("hit_right", hr_m, hr_e);
    step();
    chk("new_x", x_m, nx);
    chk("new_y", y_m, ny);
    chk("redraw_req", req_m, 1);
    mx = nx;
    my = ny;
    mdx = ndx;
    mdy = ndy;
  endtask

  initial begin
    Reset = 1'b1;
    en_p = 1'b1;
    en_b = 1'b1;
    go = 1'b0;
    draw = 1'b0;
    grant = 1'b1;
    Xcol = 1'b0;
    Ycol = 1'b0;
    Dir = 2'b00;
    sel = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 Reset = 1'b0;
    @(negedge CLOCK_50);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_req", req_m, 0);
      chk("rst_plot", plot_m, 0);
      chk("rst_frame_done", fd_m, 0);
      chk("rst_hits", {hl_m, hr_m}, 0);
      chk("rst_color", col_m, 3'b111);
      chk("rst_x", x_m, x0f());
      chk("rst_y", y_m, y0f());
    end
    grant = 1'b0;
    en_b = 1'b0;
    sel = 1'b0;
    reset_model();
    go = 1'b1;
    wait_req("pad_start");
    go = 1'b0;
    frame(1'b0, 2'b01, 1'b0, 1'b0);
    chk("up_clamp_y", y_m, 0);
    frame(1'b0, 2'b01, 1'b0, 1'b0);
    chk("up_hold_y", y_m, 0);
    frame(1'b1, 2'b00, 1'b0, 1'b0);
    repeat (18) frame(1'b0, 2'b10, 1'b0, 1'b0);
    chk("down_clamp_y", y_m, 70);
    repeat (6) frame(1'($urandom_range(0, 1)), 2'($urandom), 1'b0, 1'b0);
    scan(3'b111, 10, 1'b0);
    @(posedge CLOCK_50);
    #1 en_p = 1'b0;
    grant = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50);
      chk("dis_plot", plot_m, 0);
      chk("dis_req", req_m, 0);
      chk("dis_y_hold", y_m, my);
      @(posedge CLOCK_50);
      #1;
    end
    Reset = 1'b1;
    @(posedge CLOCK_50);
    #1 Reset = 1'b0;
    @(negedge CLOCK_50);
    chk("midrst_x", x_m, 2);
    chk("midrst_y", y_m, 2);
    chk("midrst_plot", plot_m, 0);
    en_p = 1'b1;
    #1;
    chk("midrst_idle_req", req_m, 0);
    chk("midrst_idle_plot", plot_m, 0);
    chk("midrst_color", col_m, 3'b111);
    chk("midrst_fd", fd_m, 0);
    grant = 1'b0;
    en_p = 1'b0;
    sel = 1'b1;
    en_b = 1'b1;
    reset_model();
    go = 1'b1;
    wait_req("ball_start");
    go = 1'b0;
    frame(1'b0, 2'b00, 1'b0, 1'b0);
    chk("bounce1_x", x_m, 158);
    chk("bounce1_y", y_m, 0);
    frame(1'b0, 2'b00, 1'b0, 1'b0);
    chk("bounce2_x", x_m, 156);
    chk("bounce2_y", y_m, 2);
    repeat (25) frame(1'($urandom_range(0, 1)), 2'b00, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    scan(3'b111, 4, 1'b0);
    step();
    wait_req("abort_erase_start");
    scan(3'b000, 2, 1'b0);
    @(posedge CLOCK_50);
    #1 grant = 1'b0;
    draw = 1'b1;
    @(posedge CLOCK_50);
    #1 draw = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_x", x_m, 156);
    chk("abort_y", y_m, 1);
    chk("abort_req", req_m, 0);
    repeat (12) begin
      step();
      chk("abort_idle_req", req_m, 0);
      chk("abort_no_move_x", x_m, 156);
    end
    reset_model();
    go = 1'b1;
    wait_req("ball_restart");
    go = 1'b0;
    frame(1'b0, 2'b00, 1'b0, 1'b0);
    chk("restart_x", x_m, 158);
    chk("restart_y", y_m, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
